// File: rtl/bd_rx_pkg.sv
// Shared types and default parameter values for the bd_rx serial receiver.
package bd_rx_pkg;

  localparam int unsigned ADC_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned SPB_DEF        = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned THRESH_DEF     = 128;
  localparam int unsigned INT_LEVEL_DEF  = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/bd_rx_fifo.sv
// First-word-fall-through FIFO with registered head word, valid flag and occupancy.
module bd_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop_req,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              full_c;
  logic              pop_c;
  logic              wr_c;
  logic [LW-1:0]     level_next;

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  always_comb begin
    full_c     = (level == LW'(DEPTH));
    pop_c      = pop_req && (level != '0);
    wr_c       = push && (!full_c || pop_c);
    drop_c     = push && full_c && !pop_c;
    level_next = level + LW'(wr_c) - LW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= din;
  end

  // Head register tracks the word that will sit at rd_ptr after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      valid <= (level_next != '0);
      if (pop_c && level == LW'(1)) begin
        if (wr_c) dout <= din;
      end else if (pop_c) begin
        dout <= mem[rd_ptr + AW'(1)];
      end else if (wr_c && level == '0) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/bd_rx_stream.sv
// Oversampled serial receiver: ADC slicer, start/data/stop framing FSM,
// FWFT word FIFO, sticky errors and a host interrupt.
module bd_rx_stream
  import bd_rx_pkg::*;
#(
  parameter int unsigned      ADC_W      = ADC_W_DEF,
  parameter int unsigned      DATA_W     = DATA_W_DEF,
  parameter int unsigned      SPB        = SPB_DEF,
  parameter int unsigned      FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [ADC_W-1:0] THRESH     = ADC_W'(THRESH_DEF),
  parameter int unsigned      INT_LEVEL  = INT_LEVEL_DEF
) (
  input  logic                          G_CLK_RX,
  input  logic                          G_RST_N_RX,
  input  logic [ADC_W-1:0]              ADC,
  input  logic                          rx_en,
  input  logic                          clr_err,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic                          int_rx_host,
  output logic                          frame_err,
  output logic                          ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CNT_W = $clog2(SPB + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [DATA_W-1:0]  shreg, shreg_next;
  logic               bit_s;
  logic               bit_q;
  logic               live;
  logic               push_c;
  logic               ferr_evt_c;
  logic               drop_c;

  // bit_q only reflects ADC-derived history, so a line held low across
  // reset release cannot look like a falling edge.
  always_ff @(posedge G_CLK_RX or negedge G_RST_N_RX) begin
    if (!G_RST_N_RX) begin
      bit_s <= 1'b1;
      bit_q <= 1'b0;
      live  <= 1'b0;
    end else begin
      bit_s <= (ADC >= THRESH);
      bit_q <= bit_s & live;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge G_CLK_RX or negedge G_RST_N_RX) begin
    if (!G_RST_N_RX) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    shreg_next = shreg;
    push_c     = 1'b0;
    ferr_evt_c = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bit_q && !bit_s) state_next = START;
      end
      START: begin
        if (cnt == CNT_W'(SPB / 2 - 1)) begin
          cnt_next = '0;
          idx_next = '0;
          state_next = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(SPB - 1)) begin
          cnt_next   = '0;
          shreg_next = DATA_W'({bit_s, shreg} >> 1);
          if (idx == IDX_W'(DATA_W - 1)) state_next = STOP;
          else idx_next = idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_W'(SPB - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          push_c     = bit_s;
          ferr_evt_c = !bit_s;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rx_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      push_c     = 1'b0;
      ferr_evt_c = 1'b0;
    end
  end

  bd_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (G_CLK_RX),
    .rst_n   (G_RST_N_RX),
    .push    (push_c),
    .din     (shreg),
    .pop_req (ready_out),
    .dout    (data_out),
    .valid   (valid_out),
    .level   (fifo_level),
    .drop_c  (drop_c)
  );

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge G_CLK_RX or negedge G_RST_N_RX) begin
    if (!G_RST_N_RX) begin
      frame_err   <= 1'b0;
      ovf_err     <= 1'b0;
      int_rx_host <= 1'b0;
    end else begin
      frame_err   <= ferr_evt_c | (frame_err & ~clr_err);
      ovf_err     <= drop_c | (ovf_err & ~clr_err);
      int_rx_host <= (fifo_level >= LVL_W'(INT_LEVEL)) | frame_err | ovf_err;
    end
  end

endmodule
